player_dram_ctrl: RTL
=====================

# player_dram_ctrl

Sequences all DRAM traffic for the player-record datapath: it fetches one `Player_Info` record on demand and writes back the updated record after an action completes, sharing the single DRAM AXI-lite port between the two requesters. A one-entry write-back buffer lets the action FSM return to `S_IDLE` without waiting for the write to finish. A read that targets the buffered player is served by forwarding the buffered data, with no DRAM access. Sits between the action FSM (`S_READ_DRAM` / `S_WRITE_DRAM`) and the DRAM bridge.

## Interface
- BASE_ADDR, 17'h10000, DRAM byte address of player 0.
- REC_BYTES, 12, byte stride per player record.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  one-cycle pulse: fetch record `rd_player`.
- rd_player  in  8  player number for the read.
- rd_valid  out  1  one-cycle pulse: `rd_data` is valid.
- rd_data  out  89  record as `Player_Info`.
- wb_req  in  1  one-cycle pulse: write `wb_data` to `wb_player`; legal only while `wb_ready`=1.
- wb_player  in  8  player number for the write-back.
- wb_data  in  89  record as `Player_Info`.
- wb_ready  out  1  write buffer is empty.
- busy  out  1  FSM is not in IDLE, or the buffer is full.
- ar_valid / ar_addr / ar_ready  out / out / in  1 / 17 / 1  read address channel.
- r_valid / r_data / r_resp / r_ready  in / in / in / out  1 / 96 / 2 / 1  read data channel.
- aw_valid / aw_addr / aw_ready  out / out / in  1 / 17 / 1  write address channel.
- w_valid / w_data / w_ready  out / out / in  1 / 96 / 1  write data channel.
- b_valid / b_resp / b_ready  in / in / out  1 / 2 / 1  write response channel.

## Operation
- DRAM word packing (96 bits):
  - [95:80] Exp, [79:64] MP, [63:48] HP, [47:32] Attack, [31:16] Defense.
  - [11:8] M, [4:0] D.
  - All other bits are written as 0 and ignored on read.
- Address = BASE_ADDR + REC_BYTES*player. Use 17-bit arithmetic with no overflow check; players 0–255 all fit.
- Write buffer holds {player, data} plus a full flag.
  - Loaded on `wb_req` while empty.
  - Cleared in the cycle `b_valid && b_ready` is seen.
  - `wb_ready` = !full.
- FSM states: IDLE, AR, R, AW, W, B.
- IDLE priority:
  - Pending read that hits the buffer: forward, stay in IDLE.
  - Pending read that misses the buffer: go to AR.
  - Else, buffer full: go to AW.
  - Else stay in IDLE.
- Read and drain order:
  - A read issued while the buffer is full is served before the drain.
  - A drain already in progress (AW/W/B) is never aborted. A read arriving during a drain is latched and handled when the FSM returns to IDLE.
- Channel rules:
  - AR: `ar_valid`=1 and `ar_addr` held stable until `ar_ready`, then go to R.
  - R: `r_ready`=1. On `r_valid`, capture and unpack `r_data`, pulse `rd_valid` next cycle, go to IDLE.
  - AW: `aw_valid` held until `aw_ready`, then go to W. AW and W are sequential, never concurrent.
  - W: `w_valid` held with packed buffer data until `w_ready`, then go to B.
  - B: `b_ready`=1. On `b_valid`, clear the buffer and go to IDLE.
- `r_resp` and `b_resp` are ignored.
- Simultaneous `rd_req` and `wb_req`, same player:
  - The write is loaded first.
  - The read then hits and forwards the new `wb_data`.
- Simultaneous requests, different players: the read misses and goes to DRAM. The write stays buffered and drains after the read.
- Illegal stimulus: a second `rd_req` before `rd_valid`, or `wb_req` while `wb_ready`=0, is ignored. An immediate assertion fires in simulation.

## Timing
- Reset values:
  - `wb_ready`=1.
  - All other outputs 0, including `rd_data` and all addresses and data.
  - FSM in IDLE, buffer empty, no read pending.
- Asynchronous reset mid-transaction: all valids drop immediately and the buffered write is discarded. The bench must not expect the write to complete.
- Forwarded read: `rd_req` at cycle T → `rd_valid` at T+1.
- DRAM read with zero-wait slave (`ar_ready` and `r_valid` high on first opportunity):
  - `ar_valid` at T+1, R at T+2, `rd_valid` at T+3.
  - Each slave wait cycle adds one cycle.
- Drain with zero-wait slave: `wb_req` at T → `aw_valid` at T+1, `w_valid` at T+2, `b_ready` at T+3, `wb_ready`=1 at T+4.
- A new `wb_req` is accepted in the same cycle `wb_ready` rises.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset, then `rd_req` for player 5, slave returns Exp=16'h0100, HP=16'h0050, M=3, D=14 → `ar_addr`=17'h1003C, `rd_valid` at T+3, `rd_data` fields match.
- `wb_req` for player 7 with HP=16'h1234 → `aw_addr`=17'h10054, `w_data`[63:48]=16'h1234, `w_data`[15:12]=0, `wb_ready` returns at T+4.
- `wb_req` for player 9, then `rd_req` for player 9 one cycle later → no `ar_valid`, `rd_valid` one cycle after `rd_req` with the buffered data.
- Same-cycle `wb_req` for player 2 and `rd_req` for player 3 → AR for player 3 completes first, then AW/W for player 2.
- Slave holds `aw_ready`=0 for 4 cycles while `rd_req` arrives → `aw_valid` and `aw_addr` stay stable, the read is serviced only after `b_valid`.
- Assert `rst_n`=0 during W → `w_valid` drops immediately, `wb_ready`=1 after release, the next `rd_req` proceeds normally.

Source files
------------

// File: rtl/player_dram_ctrl_if.sv
// AXI-lite DRAM port shared by the player-record read and write-back paths.
// The controller drives it through the master modport; the DRAM bridge uses slave.
interface player_dram_ctrl_if;
    logic        ar_valid;
    logic [16:0] ar_addr;
    logic        ar_ready;
    logic        r_valid;
    logic [95:0] r_data;
    logic [1:0]  r_resp;
    logic        r_ready;
    logic        aw_valid;
    logic [16:0] aw_addr;
    logic        aw_ready;
    logic        w_valid;
    logic [95:0] w_data;
    logic        w_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic        b_ready;

    modport master (
        output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
        input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
        output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
    );
endinterface

// File: rtl/player_dram_ctrl.sv
// Player-record DRAM sequencer: on-demand record fetch plus a one-entry write-back
// buffer that drains in the background and forwards its contents to matching reads.
module player_dram_ctrl #(
    parameter logic [16:0] BASE_ADDR = 17'h10000,
    parameter int unsigned REC_BYTES = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_req_i,
    input  logic [7:0]         rd_player_i,
    output logic               rd_valid_o,
    output logic [88:0]        rd_data_o,
    input  logic               wb_req_i,
    input  logic [7:0]         wb_player_i,
    input  logic [88:0]        wb_data_i,
    output logic               wb_ready_o,
    output logic               busy_o,
    player_dram_ctrl_if.master dram
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_e;

    state_e       state_q, state_d;
    logic         rd_pend_q, rd_pend_d;
    logic [7:0]   rd_pl_q, rd_pl_d;
    logic         rd_valid_q, rd_valid_d;
    logic [88:0]  rd_data_q, rd_data_d;
    logic [16:0]  ar_addr_q, ar_addr_d;
    logic [16:0]  aw_addr_q, aw_addr_d;
    logic         full_q, full_d;
    logic [7:0]   buf_pl_q, buf_pl_d;
    logic [88:0]  buf_dat_q, buf_dat_d;

    logic         rd_busy, rd_acc, rd_act, wb_acc, buf_full_eff, hit;
    logic [7:0]   rd_pl, buf_pl_eff;
    logic [88:0]  buf_dat_eff;
    logic         unused_ok;

    function automatic logic [16:0] rec_addr(input logic [7:0] player);
        return BASE_ADDR + 17'(REC_BYTES) * {9'd0, player};
    endfunction

    // A write accepted this cycle is visible to a read in the same cycle, so a
    // same-player request pair forwards the fresh write data.
    assign rd_busy      = rd_pend_q || (state_q == S_AR) || (state_q == S_R);
    assign rd_acc       = rd_req_i && !rd_busy;
    assign rd_act       = rd_acc || rd_pend_q;
    assign rd_pl        = rd_acc ? rd_player_i : rd_pl_q;
    assign wb_acc       = wb_req_i && !full_q;
    assign buf_full_eff = full_q || wb_acc;
    assign buf_pl_eff   = full_q ? buf_pl_q : wb_player_i;
    assign buf_dat_eff  = full_q ? buf_dat_q : wb_data_i;
    assign hit          = rd_act && buf_full_eff && (buf_pl_eff == rd_pl);

    always_comb begin
        // NOTE: every variable gets its hold/default value first so no path infers a latch.
        state_d    = state_q;
        rd_pend_d  = rd_pend_q;
        rd_pl_d    = rd_pl_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        ar_addr_d  = ar_addr_q;
        aw_addr_d  = aw_addr_q;
        full_d     = full_q;
        buf_pl_d   = buf_pl_q;
        buf_dat_d  = buf_dat_q;

        if (wb_acc) begin
            full_d    = 1'b1;
            buf_pl_d  = wb_player_i;
            buf_dat_d = wb_data_i;
        end

        if (hit) begin
            rd_valid_d = 1'b1;
            rd_data_d  = buf_dat_eff;
            rd_pend_d  = 1'b0;
        end else if (rd_acc) begin
            rd_pend_d = 1'b1;
            rd_pl_d   = rd_player_i;
        end

        case (state_q)
            S_IDLE: begin
                if (rd_act && !hit) begin
                    state_d   = S_AR;
                    ar_addr_d = rec_addr(rd_pl);
                    rd_pend_d = 1'b0;
                end else if (buf_full_eff) begin
                    state_d   = S_AW;
                    aw_addr_d = rec_addr(buf_pl_eff);
                end
            end
            S_AR: if (dram.ar_ready) state_d = S_R;
            S_R: begin
                if (dram.r_valid) begin
                    state_d    = S_IDLE;
                    rd_valid_d = 1'b1;
                    rd_data_d  = {dram.r_data[95:16], dram.r_data[11:8], dram.r_data[4:0]};
                end
            end
            S_AW: if (dram.aw_ready) state_d = S_W;
            S_W:  if (dram.w_ready) state_d = S_B;
            S_B: begin
                if (dram.b_valid) begin
                    state_d = S_IDLE;
                    full_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rd_pend_q  <= 1'b0;
            rd_pl_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ar_addr_q  <= '0;
            aw_addr_q  <= '0;
            full_q     <= 1'b0;
            buf_pl_q   <= '0;
            buf_dat_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all update together.
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_pl_q    <= rd_pl_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ar_addr_q  <= ar_addr_d;
            aw_addr_q  <= aw_addr_d;
            full_q     <= full_d;
            buf_pl_q   <= buf_pl_d;
            buf_dat_q  <= buf_dat_d;
        end
    end

    assign dram.ar_valid = (state_q == S_AR);
    assign dram.ar_addr  = ar_addr_q;
    assign dram.r_ready  = (state_q == S_R);
    assign dram.aw_valid = (state_q == S_AW);
    assign dram.aw_addr  = aw_addr_q;
    assign dram.w_valid  = (state_q == S_W);
    assign dram.w_data   = {buf_dat_q[88:9], 4'h0, buf_dat_q[8:5], 3'h0, buf_dat_q[4:0]};
    assign dram.b_ready  = (state_q == S_B);

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign wb_ready_o = !full_q;
    assign busy_o     = (state_q != S_IDLE) || full_q;

    assign unused_ok = ^{dram.r_resp, dram.b_resp, dram.r_data[15:12], dram.r_data[7:5]};

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(rd_req_i && rd_busy));
            assert (!(wb_req_i && full_q));
        end
    end
endmodule
